// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared UART definitions: receiver/transmitter state naming and
//            bit-timing helpers derived from clock frequency and baud rate.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver states; PARITY is only entered in 8E1 builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per bit, integer truncation.
  function automatic int unsigned uart_div(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

  // Clock cycles per half bit, used to land on the middle of the start bit.
  function automatic int unsigned uart_half(input int unsigned freq, input int unsigned baud);
    return uart_div(freq, baud) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Small first-word-fall-through byte FIFO for the UART receiver.
//            Pointers carry one extra wrap bit; full when only that bit differs.
//            A push while full is accepted only if a pop happens the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] data,
  output logic       valid,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] c_ptr_one = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign valid   = (wr_ptr_q != rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);

  // Next pointer and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + c_ptr_one;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
  end

  // Storage is cleared on reset so the head byte reads 0 while empty after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver. Synchronizes the serial line, deframes 8N1 (or 8E1)
//            characters sampled at mid-bit, and buffers bytes in a FIFO read
//            through a valid/ready handshake. Error flags are one-cycle pulses.
// Config   : define UART_RX_PARITY_EN for 8E1 framing with the parity_err port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ  = 27_000_000,
  parameter int unsigned BAUD  = 115_200,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxp,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [15:0] c_div_m1  = 16'(uart_div(FREQ, BAUD) - 1);
  localparam logic [15:0] c_half_m1 = 16'(uart_half(FREQ, BAUD) - 1);

  logic        sync1_q;
  logic        rxs_q;
  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        fifo_push;
  logic        fifo_full;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= uart_rxp;
      rxs_q   <= sync1_q;
    end
  end

  // Deframer next-state, bit capture and flag generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    fifo_push   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (cnt_q == c_half_m1) begin
          cnt_d = '0;
          idx_d = '0;
          // A line that is high again at mid-start was a glitch.
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == c_div_m1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == c_div_m1) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rxs_q};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == c_div_m1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
            fifo_push    = ~par_bad_q;
`else
            fifo_push    = 1'b1;
`endif
            // Dropped only if full and no pop frees a slot this same cycle.
            overrun_d = fifo_push & fifo_full & ~(rx_valid & rx_ready);
          end else begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Deframer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (shift_q),
    .pop       (rx_ready),
    .data      (rx_data),
    .valid     (rx_valid),
    .full      (fifo_full)
  );

endmodule
`default_nettype wire
